// File: rtl/dot_product_sched_if.sv
// rtl/dot_product_sched_if.sv - requester, engine and result bundle for dot_product_sched
interface dot_product_sched_if #(
  parameter int WIDTH = 8,
  parameter int N     = 4,
  parameter int M     = 4
);
  localparam int RW = 2*WIDTH + $clog2(N);
  localparam int IW = $clog2(M);

  logic [M-1:0]       req_valid;
  logic [M-1:0]       req_ready;
  logic [M*WIDTH-1:0] req_a;
  logic [M*WIDTH-1:0] req_b;
  logic               eng_valid;
  logic [WIDTH-1:0]   eng_a;
  logic [WIDTH-1:0]   eng_b;
  logic [RW-1:0]      eng_result;
  logic               eng_out_valid;
  logic               res_valid;
  logic [RW-1:0]      res_data;
  logic [IW-1:0]      res_id;
  logic               busy;
  logic               err;

  modport master (
    output req_valid, req_a, req_b, eng_result, eng_out_valid,
    input  req_ready, eng_valid, eng_a, eng_b, res_valid, res_data, res_id, busy, err
  );

  modport slave (
    input  req_valid, req_a, req_b, eng_result, eng_out_valid,
    output req_ready, eng_valid, eng_a, eng_b, res_valid, res_data, res_id, busy, err
  );
endinterface

// File: rtl/dot_product_sched.sv
// rtl/dot_product_sched.sv - round-robin scheduler sharing one streaming dot-product engine
module dot_product_sched #(
  parameter int WIDTH = 8,
  parameter int N     = 4,
  parameter int M     = 4,
  parameter int TAGD  = 4
) (
  input logic               clk,
  input logic               rst,
  dot_product_sched_if.slave bus
);
  localparam int RW = 2*WIDTH + $clog2(N);
  localparam int IW = $clog2(M);
  localparam int CW = $clog2(N);
  localparam int PW = $clog2(TAGD);

  typedef enum logic [1:0] {IDLE, STREAM, GAP} state_t;

  state_t        state;
  logic [IW-1:0] rr_ptr;
  logic [IW-1:0] grant;
  logic [CW-1:0] elem_cnt;
  logic [RW-1:0] snapshot;
  logic [IW-1:0] tag_mem [TAGD];
  logic [PW:0]   wr_ptr;
  logic [PW:0]   rd_ptr;

  logic          any_req;
  logic [IW-1:0] pick;
  logic          accept;
  logic          push;
  logic          pop;
  logic          fifo_empty;
  logic          fifo_full;

  // Scan from rr_ptr upward with wrap; first hit wins.
  always_comb begin
    int idx;
    any_req = 1'b0;
    pick    = '0;
    idx     = 0;
    for (int i = 0; i < M; i++) begin
      idx = int'(rr_ptr) + i;
      if (idx >= M) idx = idx - M;
      if (!any_req && bus.req_valid[idx]) begin
        any_req = 1'b1;
        pick    = IW'(idx);
      end
    end
  end

  assign fifo_empty = (wr_ptr == rd_ptr);
  assign fifo_full  = ((wr_ptr - rd_ptr) == (PW+1)'(TAGD));
  assign accept     = (state == STREAM) && bus.req_valid[grant];
  assign push       = accept && (elem_cnt == CW'(N-1));
  assign pop        = bus.eng_out_valid && !fifo_empty;

  assign bus.req_ready = (state == STREAM) ? (M'(1) << grant) : '0;
  assign bus.eng_valid = accept;
  assign bus.eng_a     = accept ? bus.req_a[int'(grant)*WIDTH +: WIDTH] : '0;
  assign bus.eng_b     = accept ? bus.req_b[int'(grant)*WIDTH +: WIDTH] : '0;
  assign bus.busy      = (state != IDLE) || !fifo_empty;

  always_ff @(posedge clk) begin
    if (rst) begin
      state         <= IDLE;
      rr_ptr        <= '0;
      grant         <= '0;
      elem_cnt      <= '0;
      snapshot      <= '0;
      wr_ptr        <= '0;
      rd_ptr        <= '0;
      bus.res_valid <= 1'b0;
      bus.res_data  <= '0;
      bus.res_id    <= '0;
      bus.err       <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (any_req && !fifo_full) begin
            grant    <= pick;
            rr_ptr   <= (pick == IW'(M-1)) ? '0 : pick + IW'(1);
            elem_cnt <= '0;
            state    <= STREAM;
          end
        end
        STREAM: begin
          if (accept) begin
            if (push) begin
              elem_cnt <= '0;
              state    <= GAP;
            end else begin
              elem_cnt <= elem_cnt + CW'(1);
            end
          end
        end
        default: state <= IDLE;
      endcase

      if (push) begin
        tag_mem[wr_ptr[PW-1:0]] <= grant;
        wr_ptr                  <= wr_ptr + (PW+1)'(1);
      end

      // The engine accumulator is never cleared, so each result is the delta since the last one.
      bus.res_valid <= pop;
      if (bus.eng_out_valid) begin
        snapshot <= bus.eng_result;
        if (!fifo_empty) begin
          bus.res_data <= bus.eng_result - snapshot;
          bus.res_id   <= tag_mem[rd_ptr[PW-1:0]];
          rd_ptr       <= rd_ptr + (PW+1)'(1);
        end else begin
          bus.err <= 1'b1;
        end
      end
    end
  end
endmodule

// File: tb/tb_dot_product_sched.sv
// tb/tb_dot_product_sched.sv - directed scoreboard bench for dot_product_sched with an engine model
module tb_dot_product_sched;
  localparam int WIDTH = 8;
  localparam int N     = 4;
  localparam int M     = 4;
  localparam int TAGD  = 4;
  localparam int RW    = 2*WIDTH + $clog2(N);
  localparam int IW    = $clog2(M);

  typedef logic [WIDTH-1:0] vec_t [N];
  typedef struct {
    logic [RW-1:0] data;
    logic [IW-1:0] id;
    int            cyc;
  } exp_t;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  dot_product_sched_if #(.WIDTH(WIDTH), .N(N), .M(M)) bus ();
  dot_product_sched #(.WIDTH(WIDTH), .N(N), .M(M), .TAGD(TAGD)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  logic             rv [M];
  logic [WIDTH-1:0] ra [M];
  logic [WIDTH-1:0] rb [M];

  always_comb begin
    bus.req_valid = '0;
    bus.req_a     = '0;
    bus.req_b     = '0;
    for (int i = 0; i < M; i++) begin
      bus.req_valid[i]           = rv[i];
      bus.req_a[i*WIDTH +: WIDTH] = ra[i];
      bus.req_b[i*WIDTH +: WIDTH] = rb[i];
    end
  end

  // Engine model: free-running accumulator, output_valid 3 cycles after each Nth element.
  wire           rst_n = ~rst;
  logic [RW-1:0] acc, r0, r1, r2;
  logic          p0, p1, p2;
  logic          spur = 1'b0;
  int            ecnt;

  assign bus.eng_out_valid = p2 | spur;
  assign bus.eng_result    = p2 ? r2 : acc;

  always @(posedge clk) begin
    if (!rst_n) begin
      acc <= '0; ecnt <= 0;
      p0 <= 1'b0; p1 <= 1'b0; p2 <= 1'b0;
      r0 <= '0; r1 <= '0; r2 <= '0;
    end else begin
      p0 <= 1'b0;
      if (bus.eng_valid) begin
        acc <= acc + RW'(bus.eng_a) * RW'(bus.eng_b);
        if (ecnt == N-1) begin
          ecnt <= 0;
          p0   <= 1'b1;
          r0   <= acc + RW'(bus.eng_a) * RW'(bus.eng_b);
        end else begin
          ecnt <= ecnt + 1;
        end
      end
      p1 <= p0; r1 <= r0;
      p2 <= p1; r2 <= r1;
    end
  end

  int   n_cmp = 0;
  int   n_err = 0;
  int   cyc   = 0;
  int   prev_last = -1;
  exp_t sbq [$];
  int   id_log [$];
  exp_t mon_e;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
    end
  endtask

  always @(negedge clk) begin
    if (!rst && bus.res_valid === 1'b1) begin
      if (sbq.size() == 0) begin
        check("unexpected_res", sbq.size(), 1);
      end else begin
        mon_e = sbq.pop_front();
        check("res_data", bus.res_data, mon_e.data);
        check("res_id", bus.res_id, mon_e.id);
        check("res_latency", cyc, mon_e.cyc);
        id_log.push_back(int'(bus.res_id));
      end
    end
  end

  task automatic send(input int id, input vec_t av, input vec_t bv,
                      input int stall_at, input int stall_len, input bit keep, input bit chk_gap);
    logic [RW-1:0] sum;
    int first_c, last_c, t;
    exp_t e;
    sum = '0; first_c = 0; last_c = 0;
    for (int k = 0; k < N; k++) begin
      if (k == stall_at) begin
        rv[id] = 1'b0;
        for (int s = 0; s < stall_len; s++) begin
          #1;
          check("stall_eng_valid", bus.eng_valid, 0);
          check("stall_grant_held", bus.req_ready[id], 1);
          @(negedge clk);
        end
      end
      rv[id] = 1'b1; ra[id] = av[k]; rb[id] = bv[k];
      t = 0;
      while (bus.req_ready[id] !== 1'b1 && t < 200) begin
        @(negedge clk);
        t++;
      end
      if (t >= 200) begin
        check("accept_timeout", t, 0);
        rv[id] = 1'b0;
        return;
      end
      if (k == 0) first_c = cyc;
      if (k == N-1) last_c = cyc;
      sum = sum + RW'(av[k]) * RW'(bv[k]);
      @(negedge clk);
    end
    if (!keep) rv[id] = 1'b0;
    e.data = sum; e.id = IW'(id); e.cyc = last_c + 4;
    sbq.push_back(e);
    if (stall_at >= N) check("contiguous_elems", last_c - first_c, N-1);
    if (chk_gap && prev_last >= 0) check("vector_gap", first_c - prev_last, 3);
    prev_last = last_c;
  endtask

  task automatic drain();
    int t;
    t = 0;
    while (sbq.size() != 0 && t < 100) begin
      @(negedge clk);
      t++;
    end
    repeat (3) @(negedge clk);
    check("drain_empty", sbq.size(), 0);
  endtask

  task automatic do_reset();
    rst = 1'b1;
    for (int i = 0; i < M; i++) begin
      rv[i] = 1'b0; ra[i] = '0; rb[i] = '0;
    end
    repeat (2) @(negedge clk);
    rst = 1'b0;
    id_log.delete();
    prev_last = -1;
  endtask

  task automatic check_reset_vals();
    check("rst_req_ready", bus.req_ready, 0);
    check("rst_eng_valid", bus.eng_valid, 0);
    check("rst_eng_a", bus.eng_a, 0);
    check("rst_eng_b", bus.eng_b, 0);
    check("rst_res_valid", bus.res_valid, 0);
    check("rst_res_data", bus.res_data, 0);
    check("rst_res_id", bus.res_id, 0);
    check("rst_busy", bus.busy, 0);
    check("rst_err", bus.err, 0);
  endtask

  initial begin
    vec_t va, vb;
    int t;
    for (int i = 0; i < M; i++) begin
      rv[i] = 1'b0; ra[i] = '0; rb[i] = '0;
    end
    repeat (2) @(negedge clk);
    check_reset_vals();
    rst = 1'b0;

    // Single vector, expected 70 from requester 0
    va = '{8'd1, 8'd2, 8'd3, 8'd4};
    vb = '{8'd5, 8'd6, 8'd7, 8'd8};
    send(0, va, vb, N, 0, 1'b0, 1'b0);
    drain();

    // Round-robin with all requesters pending
    do_reset();
    va = '{8'd1, 8'd1, 8'd1, 8'd1};
    fork
      begin send(0, va, va, N, 0, 1'b1, 1'b1); send(0, va, va, N, 0, 1'b0, 1'b1); end
      send(1, va, va, N, 0, 1'b0, 1'b1);
      send(2, va, va, N, 0, 1'b0, 1'b1);
      send(3, va, va, N, 0, 1'b0, 1'b1);
    join
    drain();
    check("rr_count", id_log.size(), 5);
    for (int i = 0; i < 5 && i < id_log.size(); i++) check("rr_order", id_log[i], i % M);

    // Accumulator overflow isolation
    do_reset();
    va = '{8'd255, 8'd255, 8'd255, 8'd255};
    for (int r = 0; r < 10; r++) send(2, va, va, N, 0, 1'b0, 1'b0);
    drain();

    // Mid-vector stall on requester 1
    do_reset();
    va = '{8'd3, 8'd4, 8'd5, 8'd6};
    vb = '{8'd7, 8'd8, 8'd9, 8'd10};
    send(1, va, vb, 2, 3, 1'b0, 1'b0);
    drain();

    // Reset after two accepted elements
    do_reset();
    rv[0] = 1'b1; ra[0] = 8'd9; rb[0] = 8'd9;
    t = 0;
    while (bus.req_ready[0] !== 1'b1 && t < 50) begin
      @(negedge clk);
      t++;
    end
    check("midrst_granted", bus.req_ready[0], 1);
    repeat (2) @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    check_reset_vals();
    rv[0] = 1'b0;
    rst = 1'b0;
    @(negedge clk);
    va = '{8'd2, 8'd2, 8'd2, 8'd2};
    vb = '{8'd3, 8'd3, 8'd3, 8'd3};
    send(0, va, vb, N, 0, 1'b0, 1'b0);
    drain();

    // Spurious engine pulse with empty tag FIFO
    do_reset();
    va = '{8'd10, 8'd20, 8'd30, 8'd40};
    send(3, va, va, N, 0, 1'b0, 1'b0);
    drain();
    spur = 1'b1;
    @(negedge clk);
    spur = 1'b0;
    check("spur_err", bus.err, 1);
    check("spur_no_res", bus.res_valid, 0);
    repeat (3) @(negedge clk);
    check("spur_err_sticky", bus.err, 1);
    va = '{8'd7, 8'd1, 8'd2, 8'd9};
    vb = '{8'd3, 8'd11, 8'd5, 8'd4};
    send(2, va, vb, N, 0, 1'b0, 1'b0);
    drain();
    check("spur_err_final", bus.err, 1);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end
endmodule
